// File: rtl/mux8_bus_arbiter_pkg.sv
// Shared widths, FSM state type and helpers for the mux8 round-robin bus arbiter.
package mux8_bus_arbiter_pkg;

  localparam int unsigned NREQ    = 8;
  localparam int unsigned SELW    = 3;
  localparam int unsigned MAXHOLD = 16;
  localparam int unsigned CNTW    = $clog2(MAXHOLD);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_bus_arbiter_rr_pick8.sv
// Combinational round-robin pick: first set request scanning last+1, last+2, ... mod 8.
module rr_pick8
  import mux8_bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic            any,
  output logic [SELW-1:0] win
);

  logic            found;
  logic [SELW-1:0] idx;

  always_comb begin
    any   = |req;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    // Offset NREQ wraps back to last itself, so the previous owner is scanned last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = last + SELW'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_bus_arbiter.sv
// Round-robin arbiter sharing one mux8 among 8 requesters; holds grant until request drops.
// Optional forced revocation after MAXHOLD cycles when MUX8_ARB_TIMEOUT_EN is defined.
module mux8_bus_arbiter
  import mux8_bus_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            tmo
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic [SELW-1:0] last_q, last_d;
  logic [NREQ-1:0] elig;
  logic            pick_any;
  logic [SELW-1:0] pick_win;

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            tmo_q, tmo_d;

  assign elig = req & ~mask_q;
  assign tmo  = tmo_q;
`else
  assign elig = req;
  assign tmo  = 1'b0;
`endif

  rr_pick8 u_pick (
    .req  (elig),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= SELW'(NREQ - 1);
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      mask_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
`ifdef MUX8_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    // A revoked requester becomes eligible again once it has dropped its request.
    mask_d  = mask_q & req;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = onehot(pick_win);
          sel_d   = pick_win;
          busy_d  = 1'b1;
          last_d  = pick_win;
          state_d = ST_GRANT;
`ifdef MUX8_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[last_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef MUX8_ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(MAXHOLD - 1)) begin
          gnt_d          = '0;
          busy_d         = 1'b0;
          tmo_d          = 1'b1;
          mask_d[last_q] = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux8_bus_arbiter.sv
// Self-checking bench for mux8_bus_arbiter: per-cycle reference model plus directed scenarios.
module tb_mux8_bus_arbiter;
  import mux8_bus_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       tmo;

  mux8_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .tmo   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 = none), rotating pointer, cycles held, revoked mask.
  int       m_owner;
  int       m_last;
  int       m_hold;
  int       m_sel;
  bit       m_tmo;
  bit [7:0] m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 7;
    m_hold  = 0;
    m_sel   = 0;
    m_tmo   = 1'b0;
    m_mask  = '0;
  endtask

  task automatic model_step();
    int revoked;
    revoked = -1;
    m_tmo   = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (m_owner < 0 && req[c] && !m_mask[c]) begin
          m_owner = c;
          m_last  = c;
          m_sel   = c;
          m_hold  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end
`ifdef MUX8_ARB_TIMEOUT_EN
    else if (m_hold == int'(MAXHOLD)) begin
      revoked = m_owner;
      m_owner = -1;
      m_tmo   = 1'b1;
    end
`endif
    else begin
      m_hold++;
    end
    m_mask = m_mask & req;
    if (revoked >= 0) m_mask[revoked] = 1'b1;
  endtask

  // One clock: advance the model from the request the DUT just sampled, then compare.
  task automatic tick();
    logic [7:0] exp_gnt;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_step();
    exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    check("model_gnt",  32'(gnt),  32'(exp_gnt));
    check("model_sel",  32'(sel),  32'(m_sel));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_tmo",  32'(tmo),  32'(m_tmo));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int         held;
    int         owner;
    bit         raise_pending;
    int         raise_idx;
    int         order_q[$];
    logic [7:0] prev_gnt;
    int         budget;
    int         cnt;
    bit         seen_tmo;
    bit         regrant;

    rst_n = 1'b0;
    req   = '0;
    model_reset();
    #2;
    do_reset();

    // Idle after reset: everything stays low.
    for (int i = 0; i < 5; i++) tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_sel", 32'(sel), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Single requester: one-edge grant latency, clears one edge after drop, sel kept.
    req = 8'h04;
    tick();
    check("single_gnt", 32'(gnt), 32'h04);
    check("single_sel", 32'(sel), 32'd2);
    tick();
    tick();
    req = 8'h00;
    tick();
    check("single_release_gnt", 32'(gnt), 32'h0);
    check("single_release_sel", 32'(sel), 32'd2);

    // Simultaneous 0 and 7 from reset: 0 first, then 7 after an idle cycle.
    do_reset();
    req = 8'h81;
    tick();
    check("pair_first_gnt", 32'(gnt), 32'h01);
    req = 8'h80;
    tick();
    check("pair_idle_gnt", 32'(gnt), 32'h00);
    tick();
    check("pair_second_gnt", 32'(gnt), 32'h80);
    check("pair_second_sel", 32'(sel), 32'd7);

    // All requesting: each owner drops 2 cycles after grant, re-raises a cycle later.
    do_reset();
    req           = 8'hFF;
    held          = 0;
    raise_pending = 1'b0;
    raise_idx     = 0;
    prev_gnt      = '0;
    budget        = 0;
    while (order_q.size() < 9 && budget < 200) begin
      tick();
      budget++;
      if (gnt != 8'h00) begin
        owner = 0;
        for (int b = 0; b < 8; b++) if (gnt[b]) owner = b;
        if (prev_gnt == 8'h00) begin
          order_q.push_back(owner);
          held = 0;
        end
        held++;
        if (held == 2) begin
          req[owner]    = 1'b0;
          raise_pending = 1'b1;
          raise_idx     = owner;
        end
      end else if (raise_pending) begin
        req[raise_idx] = 1'b1;
        raise_pending  = 1'b0;
      end
      prev_gnt = gnt;
    end
    check("rr_grant_count", 32'(order_q.size()), 32'd9);
    for (int i = 0; i < order_q.size(); i++) check("rr_order", 32'(order_q[i]), 32'(i % 8));

`ifdef MUX8_ARB_TIMEOUT_EN
    // Held request gets revoked after MAXHOLD cycles and must toggle before regrant.
    do_reset();
    req      = 8'h08;
    cnt      = 0;
    seen_tmo = 1'b0;
    budget   = 0;
    tick();
    while (gnt == 8'h08 && budget < 40) begin
      cnt++;
      budget++;
      tick();
    end
    check("tmo_hold_cycles", 32'(cnt), 32'd16);
    check("tmo_pulse", 32'(tmo), 32'd1);
    tick();
    check("tmo_pulse_end", 32'(tmo), 32'd0);
    regrant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt != 8'h00) regrant = 1'b1;
    end
    check("tmo_masked", 32'(regrant), 32'd0);
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    check("tmo_regrant", 32'(gnt), 32'h08);
    req = 8'h00;
    tick();
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) req = 8'($urandom);
      tick();
    end

    // Asynchronous reset while requester 5 owns the bus.
    do_reset();
    req    = 8'h20;
    budget = 0;
    tick();
    while (gnt != 8'h20 && budget < 20) begin
      budget++;
      tick();
    end
    check("async_pre_gnt", 32'(gnt), 32'h20);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_sel", 32'(sel), 32'h0);
    model_reset();
    req = 8'h21;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_gnt", 32'(gnt), 32'h01);
    check("post_reset_sel", 32'(sel), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
